// File: rtl/processors_control_param.sv
// Sequencer for the matrix-vector processor array: wipe, clear, compute, drain per pass, then done.
// Latency: 2 + ceil(N/NUM_PROC)*(1+N) + N cycles from accepted start to done when unstalled.
// Backpressure: av_empty freezes COMPUTE, result_full freezes DRAIN; optional stall counter via PROC_CTRL_STALL_CNT_EN.
module processors_control_param #(
  parameter int NUM_PROC = 4,
  parameter int N_MAX    = 16,
  parameter int N_WIDTH  = 5,
  localparam int PSEL_W  = (NUM_PROC > 1) ? $clog2(NUM_PROC) : 1,
  localparam int CNT_W   = $clog2(N_MAX + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [N_WIDTH-1:0] N,
  input  logic               av_empty,
  input  logic               result_full,
  output logic               busy,
  output logic               done,
  output logic               err_bad_n,
  output logic               rst_FIFO_out,
  output logic               rst_processor,
  output logic               pop_a_v,
  output logic               push_result,
  output logic [PSEL_W-1:0]  processor_number,
  output logic [N_WIDTH-1:0] pass_index
`ifdef PROC_CTRL_STALL_CNT_EN
  ,
  output logic [15:0]        stall_cycles
`endif
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WIPE    = 3'd1,
    CLEAR   = 3'd2,
    COMPUTE = 3'd3,
    DRAIN   = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   n_lat;
  logic [CNT_W-1:0]   rows_left;
  logic [CNT_W-1:0]   rows_pass;
  logic [CNT_W-1:0]   col_cnt;
  logic [PSEL_W-1:0]  row_idx;
  logic [N_WIDTH-1:0] pass_q;
  logic               err_q;

  logic               n_ok;
  logic               accept;
  logic [CNT_W-1:0]   col_next;
  logic               last_col;
  logic               last_row;
  logic [CNT_W-1:0]   rows_rem;

  // Start qualification and end-of-row / end-of-pass detection.
  always_comb begin
    n_ok     = (N != '0) && (int'(N) <= N_MAX);
    accept   = (state == IDLE) && start && n_ok;
    col_next = col_cnt + CNT_W'(1);
    last_col = (col_next == n_lat);
    last_row = (int'(row_idx) == (int'(rows_pass) - 1));
    rows_rem = rows_left - rows_pass;
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state and strobes; every output is decoded from current state and counters.
  always_comb begin
    state_n          = state;
    busy             = (state != IDLE);
    done             = 1'b0;
    err_bad_n        = err_q;
    rst_FIFO_out     = 1'b0;
    rst_processor    = 1'b0;
    pop_a_v          = 1'b0;
    push_result      = 1'b0;
    processor_number = '0;
    pass_index       = pass_q;
    case (state)
      IDLE: begin
        rst_processor = 1'b1;
        if (accept) state_n = WIPE;
      end
      WIPE: begin
        rst_FIFO_out  = 1'b1;
        rst_processor = 1'b1;
        state_n       = CLEAR;
      end
      CLEAR: begin
        rst_processor = 1'b1;
        state_n       = COMPUTE;
      end
      COMPUTE: begin
        pop_a_v = ~av_empty;
        if (pop_a_v && last_col) state_n = DRAIN;
      end
      DRAIN: begin
        push_result      = ~result_full;
        processor_number = row_idx;
        if (push_result && last_row) begin
          state_n = (rows_rem == '0) ? DONE : CLEAR;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Job counters: latch N on accept, count columns per pop, rows per push, passes per drain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      n_lat     <= '0;
      rows_left <= '0;
      rows_pass <= '0;
      col_cnt   <= '0;
      row_idx   <= '0;
      pass_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= (state == IDLE) && start && !n_ok;
      case (state)
        IDLE: begin
          if (accept) begin
            n_lat     <= CNT_W'(N);
            rows_left <= CNT_W'(N);
            pass_q    <= '0;
          end
        end
        CLEAR: begin
          col_cnt <= '0;
          // The final pass may cover fewer rows than there are processors.
          if (int'(rows_left) >= NUM_PROC) rows_pass <= CNT_W'(NUM_PROC);
          else                             rows_pass <= rows_left;
        end
        COMPUTE: begin
          if (pop_a_v) begin
            col_cnt <= col_next;
            if (last_col) row_idx <= '0;
          end
        end
        DRAIN: begin
          if (push_result) begin
            if (last_row) begin
              rows_left <= rows_rem;
              pass_q    <= pass_q + N_WIDTH'(1);
            end else begin
              row_idx <= row_idx + PSEL_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef PROC_CTRL_STALL_CNT_EN
  // Saturating count of cycles lost to an empty operand FIFO or a full result FIFO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
    end else if (accept) begin
      stall_cycles <= '0;
    end else if (((state == COMPUTE) && av_empty) || ((state == DRAIN) && result_full)) begin
      if (stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_processors_control_param.sv
// Directed bench for processors_control_param with NUM_PROC=4, N_MAX=16.
// Cycle 0 is the IDLE cycle with start high; events are indexed in cycles after it.
// Inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
module tb_processors_control_param;
  logic       clk;
  logic       reset;
  logic       start;
  logic [4:0] N;
  logic       av_empty;
  logic       result_full;
  logic       busy, done, err_bad_n, rst_FIFO_out, rst_processor, pop_a_v, push_result;
  logic [1:0] processor_number;
  logic [4:0] pass_index;
`ifdef PROC_CTRL_STALL_CNT_EN
  logic [15:0] stall_cycles;
`endif

  processors_control_param #(.NUM_PROC(4), .N_MAX(16), .N_WIDTH(5)) dut (
    .clk(clk), .reset(reset), .start(start), .N(N),
    .av_empty(av_empty), .result_full(result_full),
    .busy(busy), .done(done), .err_bad_n(err_bad_n),
    .rst_FIFO_out(rst_FIFO_out), .rst_processor(rst_processor),
    .pop_a_v(pop_a_v), .push_result(push_result),
    .processor_number(processor_number), .pass_index(pass_index)
`ifdef PROC_CTRL_STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Per-job observations.
  int pops, pushes, wipe_cnt, wipe_cyc, first_pop, err_cnt, err_cyc;
  int busy_cnt, done_cnt, done_cyc, last_done_cyc, held_pn;
  int pn_code, pass_code;
  logic [63:0] busy_vec;
  int s_busy, s_rstp, s_pop, s_pass, s_done;

  task automatic run_job(input int n, input int budget, input int start_until,
                         input int e_from, input int e_len, input int f_from, input int f_len,
                         input int rst_at);
    pops = 0; pushes = 0; wipe_cnt = 0; wipe_cyc = -1; first_pop = -1;
    err_cnt = 0; err_cyc = -1; busy_cnt = 0; done_cnt = 0; done_cyc = -1;
    last_done_cyc = -1; held_pn = -1; pn_code = 0; pass_code = 0; busy_vec = '0;
    s_busy = -1; s_rstp = -1; s_pop = -1; s_pass = -1; s_done = -1;
    @(posedge clk); #1;
    start = 1'b1; N = 5'(n); av_empty = 1'b0; result_full = 1'b0;
    @(negedge clk);
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk); #1;
      if (k >= start_until) start = 1'b0;
      av_empty    = (k >= e_from) && (k < e_from + e_len);
      result_full = (k >= f_from) && (k < f_from + f_len);
      if (k == rst_at)     reset = 1'b0;
      if (k == rst_at + 2) reset = 1'b1;
      @(negedge clk);
      if (pop_a_v) begin
        pops++;
        if (first_pop < 0) first_pop = k;
      end
      if (push_result) begin
        pushes++;
        pn_code   = (pn_code << 4) | int'(processor_number);
        pass_code = (pass_code << 4) | int'(pass_index);
      end
      if (rst_FIFO_out) begin
        wipe_cnt++;
        if (wipe_cyc < 0) wipe_cyc = k;
      end
      if (err_bad_n) begin
        err_cnt++;
        if (err_cyc < 0) err_cyc = k;
      end
      if (busy) busy_cnt++;
      busy_vec[k] = busy;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = k;
        last_done_cyc = k;
      end
      if (result_full && busy && !push_result) held_pn = int'(processor_number);
      if (k == rst_at) begin
        s_busy = int'(busy); s_rstp = int'(rst_processor); s_pop = int'(pop_a_v);
        s_pass = int'(pass_index); s_done = int'(done);
      end
    end
    start = 1'b0; av_empty = 1'b0; result_full = 1'b0;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; N = '0; av_empty = 1'b0; result_full = 1'b0;
    #12;
    chk("rst_busy",  int'(busy), 0);
    chk("rst_done",  int'(done), 0);
    chk("rst_err",   int'(err_bad_n), 0);
    chk("rst_wipe",  int'(rst_FIFO_out), 0);
    chk("rst_rstp",  int'(rst_processor), 1);
    chk("rst_pop",   int'(pop_a_v), 0);
    chk("rst_push",  int'(push_result), 0);
    chk("rst_pn",    int'(processor_number), 0);
    chk("rst_pass",  int'(pass_index), 0);
`ifdef PROC_CTRL_STALL_CNT_EN
    chk("rst_stall", int'(stall_cycles), 0);
`endif
    #5 reset = 1'b1;

    // N=4, single pass.
    run_job(4, 14, 1, -10, 0, -10, 0, -10);
    chk("n4_wipe_cyc",  wipe_cyc, 1);
    chk("n4_wipe_cnt",  wipe_cnt, 1);
    chk("n4_first_pop", first_pop, 3);
    chk("n4_pops",      pops, 4);
    chk("n4_pushes",    pushes, 4);
    chk("n4_pn_seq",    pn_code, 32'h0123);
    chk("n4_done_cyc",  done_cyc, 11);
    chk("n4_done_cnt",  done_cnt, 1);
    chk("n4_busy_after", int'(busy_vec[12]), 0);
`ifdef PROC_CTRL_STALL_CNT_EN
    chk("n4_stall", int'(stall_cycles), 0);
`endif

    // N=6, two passes with a short final pass.
    run_job(6, 24, 1, -10, 0, -10, 0, -10);
    chk("n6_pops",     pops, 12);
    chk("n6_pushes",   pushes, 6);
    chk("n6_pn_seq",   pn_code, 32'h012301);
    chk("n6_pass_seq", pass_code, 32'h000011);
    chk("n6_done_cyc", done_cyc, 22);

    // N=1, smallest legal job.
    run_job(1, 7, 1, -10, 0, -10, 0, -10);
    chk("n1_pops",     pops, 1);
    chk("n1_pushes",   pushes, 1);
    chk("n1_pn_seq",   pn_code, 0);
    chk("n1_done_cyc", done_cyc, 5);

    // Illegal N values.
    run_job(0, 4, 1, -10, 0, -10, 0, -10);
    chk("n0_err_cnt",  err_cnt, 1);
    chk("n0_err_cyc",  err_cyc, 1);
    chk("n0_busy",     busy_cnt, 0);
    chk("n0_activity", pops + pushes + done_cnt, 0);
    run_job(17, 4, 1, -10, 0, -10, 0, -10);
    chk("n17_err_cnt",  err_cnt, 1);
    chk("n17_err_cyc",  err_cyc, 1);
    chk("n17_busy",     busy_cnt, 0);
    chk("n17_activity", pops + pushes + done_cnt, 0);

    // N=4 with operand underflow after the 2nd pop and result backpressure at the 3rd push.
    run_job(4, 18, 1, 5, 3, 12, 2, -10);
    chk("st_pops",     pops, 4);
    chk("st_pushes",   pushes, 4);
    chk("st_pn_seq",   pn_code, 32'h0123);
    chk("st_held_pn",  held_pn, 2);
    chk("st_done_cyc", done_cyc, 16);
`ifdef PROC_CTRL_STALL_CNT_EN
    chk("st_stall", int'(stall_cycles), 5);
`endif

    // N=8 with reset during COMPUTE of the second pass (cycles 16..23).
    run_job(8, 26, 1, -10, 0, -10, 0, 18);
    chk("rs_busy",     s_busy, 0);
    chk("rs_rstp",     s_rstp, 1);
    chk("rs_pop",      s_pop, 0);
    chk("rs_pass",     s_pass, 0);
    chk("rs_done",     s_done, 0);
    chk("rs_no_done",  done_cnt, 0);
    run_job(2, 9, 1, -10, 0, -10, 0, -10);
    chk("n2_pushes",   pushes, 2);
    chk("n2_pn_seq",   pn_code, 32'h01);
    chk("n2_done_cyc", done_cyc, 7);

    // start held high: one job, IDLE cycle after done, then a second job.
    run_job(4, 24, 14, -10, 0, -10, 0, -10);
    chk("hd_first_done", done_cyc, 11);
    chk("hd_idle_gap",   int'(busy_vec[12]), 0);
    chk("hd_restart",    int'(busy_vec[13]), 1);
    chk("hd_done_cnt",   done_cnt, 2);
    chk("hd_last_done",  last_done_cyc, 23);
    chk("hd_wipe_cnt",   wipe_cnt, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
